// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// Module   : dmem_arbiter_pkg
// Brief    : Shared types and constants for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic c_port0          = 1'b0;
    localparam logic c_port1          = 1'b1;
    localparam int   c_addr_w_default = 13;

    // An address is legal only when every bit above the memory's word index is zero.
    function automatic logic addr_in_range(input logic [31:0] addr, input int addr_w);
        return ((addr >> addr_w) == 32'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Requester handshakes and data-memory lines of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if;

    logic        req0, req1;
    logic        we0, we1;
    logic [31:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic        err0, err1;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memWrite;
    logic [31:0] memReadData;

    // Requesters plus the memory itself sit on the master side.
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, memReadData,
        input  gnt0, gnt1, ack0, ack1, rdata0, rdata1, err0, err1,
        input  memAddress, memWriteData, memWrite
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, memReadData,
        output gnt0, gnt1, ack0, ack1, rdata0, rdata1, err0, err1,
        output memAddress, memWriteData, memWrite
    );

endinterface

`default_nettype wire

// File: rtl/dmem_arbiter_starve_counter.sv
// ============================================================================
// Module   : dmem_arbiter_starve_counter
// Brief    : Saturating wait counter that flags when port 1 must be forced in.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter_starve_counter #(
    parameter int MAX_WAIT = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_gnt,
    output logic o_at_limit
);

    localparam logic [7:0] c_limit = 8'(MAX_WAIT);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (!i_req || i_gnt) begin
            r_cnt <= 8'd0;
        end else if (r_cnt < c_limit) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_at_limit = (r_cnt == c_limit);

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port data-memory arbiter, port 0 priority with starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = c_addr_w_default,
    parameter int MAX_WAIT = 7
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sel;
    logic        r_we;
    logic        r_inrange;
    logic        r_ack0, r_ack1;
    logic        r_err0, r_err1;
    logic [31:0] r_rdata0, r_rdata1;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_we;

    logic        w_any_req;
    logic        w_win;
    logic        w_load;
    logic        w_at_limit;
    logic        w_gnt0, w_gnt1;
    logic        w_win_we;
    logic        w_win_inr;
    logic [31:0] w_win_addr;
    logic [31:0] w_win_wdata;
    logic [31:0] w_resp_data;

    dmem_arbiter_starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .i_req      (bus.req1),
        .i_gnt      (w_gnt1),
        .o_at_limit (w_at_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_any_req   = bus.req0 | bus.req1;
        w_win       = bus.req1 & (~bus.req0 | w_at_limit);
        w_win_addr  = (w_win == c_port1) ? bus.addr1  : bus.addr0;
        w_win_wdata = (w_win == c_port1) ? bus.wdata1 : bus.wdata0;
        w_win_we    = (w_win == c_port1) ? bus.we1    : bus.we0;
        w_win_inr   = addr_in_range(w_win_addr, ADDR_W);
        w_resp_data = (!r_we && r_inrange) ? bus.memReadData : 32'd0;
        w_load      = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                // A request still high here is a fresh one; chain straight into ISSUE.
                if (w_any_req) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel       <= c_port0;
            r_we        <= 1'b0;
            r_inrange   <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_we    <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_err0      <= 1'b0;
            r_err1      <= 1'b0;
            r_rdata0    <= 32'd0;
            r_rdata1    <= 32'd0;
        end else begin
            r_mem_we <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            if (w_load) begin
                r_sel       <= w_win;
                r_we        <= w_win_we;
                r_inrange   <= w_win_inr;
                r_mem_addr  <= w_win_addr;
                r_mem_wdata <= w_win_wdata;
                r_mem_we    <= w_win_we & w_win_inr;
            end
            if (r_state == ST_RESP) begin
                if (r_sel == c_port1) begin
                    r_ack1   <= 1'b1;
                    r_err1   <= ~r_inrange;
                    r_rdata1 <= w_resp_data;
                end else begin
                    r_ack0   <= 1'b1;
                    r_err0   <= ~r_inrange;
                    r_rdata0 <= w_resp_data;
                end
            end
        end
    end

    assign w_gnt0 = (r_state == ST_ISSUE) && (r_sel == c_port0);
    assign w_gnt1 = (r_state == ST_ISSUE) && (r_sel == c_port1);

    assign bus.gnt0         = w_gnt0;
    assign bus.gnt1         = w_gnt1;
    assign bus.ack0         = r_ack0;
    assign bus.ack1         = r_ack1;
    assign bus.err0         = r_err0;
    assign bus.err1         = r_err1;
    assign bus.rdata0       = r_rdata0;
    assign bus.rdata1       = r_rdata1;
    assign bus.memAddress   = r_mem_addr;
    assign bus.memWriteData = r_mem_wdata;
    assign bus.memWrite     = r_mem_we;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed self-checking bench for dmem_arbiter with a 1-cycle memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    dmem_arbiter_if bus ();

    dmem_arbiter #(
        .ADDR_W   (13),
        .MAX_WAIT (3)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read data valid the cycle after the address; backdoor for preload.
    logic [31:0] mem [0:8191];
    logic        bd_we;
    logic [12:0] bd_addr;
    logic [31:0] bd_data;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (bus.memWrite) begin
            mem[bus.memAddress[12:0]] <= bus.memWriteData;
        end
        bus.memReadData <= mem[bus.memAddress[12:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic bd_write(input logic [12:0] a, input logic [31:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        tick();
        bd_we   = 1'b0;
    endtask

    // One complete access from IDLE on port p, checked cycle by cycle.
    task automatic access(input string tag, input bit p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic exp_mw, input logic [31:0] exp_rd,
                          input logic exp_err);
        if (!p) begin
            bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end
        tick();
        check_eq({tag, "_gnt"},       p ? bus.gnt1 : bus.gnt0, 32'd1);
        check_eq({tag, "_gnt_other"}, p ? bus.gnt0 : bus.gnt1, 32'd0);
        check_eq({tag, "_memaddr"},   bus.memAddress, a);
        check_eq({tag, "_memwrite"},  bus.memWrite, exp_mw);
        if (exp_mw) check_eq({tag, "_memwdata"}, bus.memWriteData, d);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        check_eq({tag, "_resp_memwrite"}, bus.memWrite, 32'd0);
        check_eq({tag, "_resp_ack"},      p ? bus.ack1 : bus.ack0, 32'd0);
        tick();
        check_eq({tag, "_ack"},       p ? bus.ack1 : bus.ack0, 32'd1);
        check_eq({tag, "_rdata"},     p ? bus.rdata1 : bus.rdata0, exp_rd);
        check_eq({tag, "_err"},       p ? bus.err1 : bus.err0, exp_err);
        check_eq({tag, "_ack_other"}, p ? bus.ack0 : bus.ack1, 32'd0);
        tick();
        check_eq({tag, "_ack_pulse"},  p ? bus.ack1 : bus.ack0, 32'd0);
        check_eq({tag, "_err_pulse"},  p ? bus.err1 : bus.err0, 32'd0);
        check_eq({tag, "_rdata_hold"}, p ? bus.rdata1 : bus.rdata0, exp_rd);
    endtask

    logic [11:0] exp_g0;
    logic [11:0] exp_g1;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bd_we    = 1'b0;
        bd_addr  = '0;
        bd_data  = '0;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        rst      = 1'b1;

        tick();
        bd_write(13'd5, 32'hDEADBEEF);
        bd_write(13'd1, 32'h11111111);
        bd_write(13'd2, 32'h22222222);
        bd_write(13'd3, 32'h33333333);
        rst = 1'b0;

        check_eq("rst_gnt0",   bus.gnt0, 32'd0);
        check_eq("rst_gnt1",   bus.gnt1, 32'd0);
        check_eq("rst_ack0",   bus.ack0, 32'd0);
        check_eq("rst_ack1",   bus.ack1, 32'd0);
        check_eq("rst_err0",   bus.err0, 32'd0);
        check_eq("rst_rdata0", bus.rdata0, 32'd0);
        check_eq("rst_rdata1", bus.rdata1, 32'd0);
        check_eq("rst_maddr",  bus.memAddress, 32'd0);
        check_eq("rst_mwdata", bus.memWriteData, 32'd0);
        check_eq("rst_mwrite", bus.memWrite, 32'd0);

        access("rd0",    1'b0, 1'b0, 32'd5,      32'd0,          1'b0, 32'hDEADBEEF, 1'b0);
        access("wr1",    1'b1, 1'b1, 32'd100,    32'h12345678,   1'b1, 32'd0,        1'b0);
        access("rd1",    1'b1, 1'b0, 32'd100,    32'd0,          1'b0, 32'h12345678, 1'b0);
        access("oor_wr", 1'b0, 1'b1, 32'h2000,   32'hAAAA5555,   1'b0, 32'd0,        1'b1);
        access("oor_rd", 1'b0, 1'b0, 32'h2000,   32'd0,          1'b0, 32'd0,        1'b1);

        // Back-to-back reads of 1,2,3: address advances after each grant.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'd1;
        tick();
        check_eq("b2b_gnt_a", bus.gnt0, 32'd1);
        check_eq("b2b_addr_a", bus.memAddress, 32'd1);
        bus.addr0 = 32'd2;
        tick();
        check_eq("b2b_gap_a", bus.gnt0, 32'd0);
        tick();
        check_eq("b2b_gnt_b", bus.gnt0, 32'd1);
        check_eq("b2b_addr_b", bus.memAddress, 32'd2);
        check_eq("b2b_ack_a", bus.ack0, 32'd1);
        check_eq("b2b_data_a", bus.rdata0, 32'h11111111);
        bus.addr0 = 32'd3;
        tick();
        check_eq("b2b_gap_b", bus.gnt0, 32'd0);
        tick();
        check_eq("b2b_gnt_c", bus.gnt0, 32'd1);
        check_eq("b2b_addr_c", bus.memAddress, 32'd3);
        check_eq("b2b_ack_b", bus.ack0, 32'd1);
        check_eq("b2b_data_b", bus.rdata0, 32'h22222222);
        bus.req0 = 1'b0;
        tick();
        tick();
        check_eq("b2b_ack_c", bus.ack0, 32'd1);
        check_eq("b2b_data_c", bus.rdata0, 32'h33333333);
        check_eq("b2b_idle_gnt", bus.gnt0, 32'd0);
        tick();

        // Contention with MAX_WAIT=3: grants at cycles 1,3,5,...: 0,0,1,0,0,1.
        exp_g0 = 12'h145;
        exp_g1 = 12'h410;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'd1;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'd2;
        for (int c = 1; c <= 12; c++) begin
            tick();
            check_eq($sformatf("cont_gnt0_c%0d", c), bus.gnt0, 32'(exp_g0[c-1]));
            check_eq($sformatf("cont_gnt1_c%0d", c), bus.gnt1, 32'(exp_g1[c-1]));
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        check_eq("cont_last_ack1", bus.ack1, 32'd1);
        check_eq("cont_last_rdata1", bus.rdata1, 32'h22222222);
        tick();
        tick();

        // Reset during the ISSUE cycle of a port 1 write.
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'd200; bus.wdata1 = 32'hCAFEF00D;
        tick();
        check_eq("rma_gnt1", bus.gnt1, 32'd1);
        check_eq("rma_mwrite_issue", bus.memWrite, 32'd1);
        rst = 1'b1;
        bus.req1 = 1'b0; bus.we1 = 1'b0;
        tick();
        check_eq("rma_mwrite", bus.memWrite, 32'd0);
        check_eq("rma_ack1", bus.ack1, 32'd0);
        check_eq("rma_gnt1_off", bus.gnt1, 32'd0);
        check_eq("rma_rdata0", bus.rdata0, 32'd0);
        check_eq("rma_rdata1", bus.rdata1, 32'd0);
        check_eq("rma_maddr", bus.memAddress, 32'd0);
        check_eq("rma_mwdata", bus.memWriteData, 32'd0);
        rst = 1'b0;
        tick();
        check_eq("rma_no_ack1", bus.ack1, 32'd0);
        check_eq("rma_idle_gnt0", bus.gnt0, 32'd0);
        access("rma_rd0", 1'b0, 1'b0, 32'd5, 32'd0, 1'b0, 32'hDEADBEEF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory (DataMem) between the processor load/store path (port 0) and the UART receive/loader path (port 1). It serialises accesses, drives the memory's address, write-data and write-enable lines, and returns read data and completion to the winning requester. Port 0 has fixed priority; a starvation counter guarantees port 1 progress.

## Interface
Parameters:
- ADDR_W, 13, word-address width of the data memory (depth 2**ADDR_W)
- MAX_WAIT, 7, cycles port 1 may wait with req high before forced grant (1..255)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request, held until gnt
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  32  word address; stable while req high
- wdata0 / wdata1  in  32  write data; stable while req high
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted
- ack0 / ack1  out  1  one-cycle pulse: access complete, rdata valid
- rdata0 / rdata1  out  32  read data (0 for writes / errors), held until next ack on that port
- err0 / err1  out  1  one-cycle pulse with ack: address out of range
- memAddress  out  32  to memory address
- memWriteData  out  32  to memory write data
- memWrite  out  1  to memory write enable
- memReadData  in  32  from memory; valid in cycle after address is driven

## Operation
- FSM states: IDLE, ISSUE, RESP. Registered owner bit sel (0/1).
- IDLE: if any req, pick winner, -> ISSUE; else stay.
- Winner: port 1 if req1 && (!req0 || waitCnt == MAX_WAIT); else port 0.
- ISSUE: gnt[sel]=1; memAddress = addr[sel]; memWriteData = wdata[sel]; memWrite = we[sel] && inRange. -> RESP.
- inRange: addr[31:ADDR_W] == 0. Out of range: memWrite held 0, read result forced 0, err pulses.
- RESP: capture memReadData (or 0) into rdata[sel]; ack[sel], err[sel] registered, visible next cycle. If any req pending (excluding the port just granted only if its req has dropped), arbitrate and -> ISSUE directly; else -> IDLE.
- waitCnt (8 bit): increments each cycle req1 high and port 1 not granted, saturates at MAX_WAIT; clears to 0 on gnt1 or when req1 low.
- Simultaneous req0/req1 with waitCnt < MAX_WAIT: port 0 wins.
- Requester re-asserting req in the cycle after its gnt is a new request.

## Timing
- Reset values: state IDLE, sel 0, waitCnt 0, all gnt/ack/err 0, rdata0/1 0, memAddress 0, memWriteData 0, memWrite 0.
- req sampled high in IDLE at cycle N -> gnt and memory lines driven cycle N+1 -> memReadData sampled end of cycle N+2 -> ack/rdata visible cycle N+3.
- Sustained throughput: one access per 2 cycles (ISSUE/RESP back-to-back).
- memWrite is high for exactly one cycle (ISSUE) per write; never high outside ISSUE.
- Reset mid-access: in-flight access dropped, no ack issued, memWrite low from first reset edge; no partial state survives.
- Memory lines hold last value outside ISSUE except memWrite (0).

## Structure
- Shared package: state enum (IDLE/ISSUE/RESP), port index constants, default ADDR_W.
- One sub-module natural: starve_counter (saturating wait counter with clear/increment/limit compare); arbitration and FSM stay in top.

## Test plan
- Single read port 0: mem[5]=0xDEADBEEF, req0 addr=5 at cycle 0 -> gnt0 cycle 1, ack0 cycle 3, rdata0=0xDEADBEEF, no port 1 activity.
- Write then read port 1: write 0x12345678 to addr 100, then read 100 -> memWrite high one cycle with memAddress=100, read ack1 with rdata1=0x12345678.
- Contention: req0 and req1 both held continuously, MAX_WAIT=3 -> port 0 granted until waitCnt hits 3, then gnt1, then counter cleared; port 1 granted at least once every 4 grants.
- Out of range: req0 write addr=0x2000 (ADDR_W=13) -> memWrite stays 0, ack0 with err0=1; read same addr -> rdata0=0, err0=1.
- Back-to-back: req0 reads addr 1,2,3 with req re-asserted after each gnt -> gnts spaced exactly 2 cycles, acks in order with correct data.
- Reset mid-access: assert rst during ISSUE of a write -> no ack, memWrite 0 after reset edge, all outputs at reset values, next request serviced normally.
